wbu: RTL and testbench
======================

// Module: wbu
// PURPOSE
//  Load-return / write-back unit: the read-side counterpart of the MEM-stage store path.
//  Holds the MEM/WB pipeline register and consumes the data-memory read port (DM_DO).
//  Extracts, aligns and sign/zero-extends load data, and produces the register-file write.
//  Sits between memu and the register file; also feeds the forwarding and hazard logic.
// PARAMETERS
//  DATA_W   32  datapath / DM word width (fixed 32 for RV32I; parameter for lint only)
//  MNEM_W   6   width of the decoded mnemonic bus
//  HOLD_DO  1   1 = capture load result on the first stall cycle (SRAM DO may change while stalled)
// PORTS
//  clk         in   1       clock, rising edge
//  rst         in   1       asynchronous, active-low reset
//  i_stall     in   1       hold MEM/WB register and outputs
//  i_flush     in   1       insert bubble into MEM/WB; has priority over i_stall
//  i_mnemonic  in   6       mnemonic from memu (o_mnemonic)
//  i_rd_addr   in   5       destination register
//  i_ALUout    in   32      ALU result; the byte address for loads
//  i_rd_wr     in   1       register-write request
//  i_DM_DO     in   32      DM read data, valid the cycle after memu presents DM_addr
//  o_mnemonic  out  6       registered mnemonic
//  o_rd_addr   out  5       register-file write address
//  o_rd_data   out  32      register-file write data
//  o_rd_wr     out  1       register-file write enable
//  o_is_load   out  1       WB instruction is LB/LH/LW/LBU/LHU
//  o_misalign  out  1       load address misaligned; the write is suppressed
// BEHAVIOUR
//  Reset (rst=0, async): all registers 0; mnemonic = NOP (0).
//   Outputs: o_rd_wr=0, o_rd_addr=0, o_rd_data=0, o_is_load=0, o_misalign=0, hold_vld=0.
//  Rising edge, i_flush=1: register <= bubble (mnemonic NOP, rd_wr 0, rd_addr 0, ALUout 0); hold_vld <= 0.
//  Rising edge, i_stall=1 (no flush): register holds.
//   If HOLD_DO and !hold_vld: hold_q <= extracted data; hold_vld <= 1.
//  Rising edge, otherwise: register <= i_* inputs; hold_vld <= 0.
//  Latency: load data reaches o_rd_data in the same cycle DM_DO is valid (one cycle after memu's address).
//   o_rd_data is combinational from the MEM/WB register, i_DM_DO and hold_q.
//  Extraction, with off = ALUout_q[1:0]:
//   LB:  sext(DO[8*off +: 8])      LBU: zext(DO[8*off +: 8])
//   LH:  sext(off[1] ? DO[31:16] : DO[15:0])      LHU: same half-word, zext
//   LW:  DO
//   Non-load: o_rd_data = ALUout_q
//  When hold_vld=1, o_rd_data = hold_q, regardless of i_DM_DO.
//  Misalign: LH/LHU with off[0]=1, or LW with off!=0 -> o_misalign=1.
//   In that case o_rd_wr=0 and o_rd_data = extracted value; it is don't-care.
//  x0 guard: o_rd_wr = rd_wr_q & (rd_addr_q != 0) & !o_misalign.
//  Stores, branches and NOP: o_is_load=0; o_rd_wr follows rd_wr_q (0 from decode).
//  Simultaneous flush+stall: flush wins.
//  Reset mid-stall: hold_vld cleared; outputs return to reset values immediately.
// STRUCTURE
//  rv32i_pkg: mnemonic localparams (NOP, LB, LH, LW, LBU, LHU, ...), MNEM_W, and the is_load() function.
//  mem_wb: sub-module, the pipeline register with stall/flush/async active-low reset.
//  load_align: combinational extraction and misalign check, in this file.
// TESTING
//  LB, ALUout=0x103, DO=0x80FF_1234 -> o_rd_data=0xFFFF_FF80, o_rd_wr=1.
//  LHU, ALUout=0x202, DO=0x8001_5555 -> o_rd_data=0x0000_8001; LH, same inputs -> 0xFFFF_8001.
//  LW, ALUout=0x101 -> o_misalign=1, o_rd_wr=0.
//   Next cycle: LW, ALUout=0x100, DO=0xDEAD_BEEF -> o_rd_data=0xDEAD_BEEF, o_misalign=0.
//  LB, off=0, DO=0x0000_007F; stall 3 cycles while DO changes to 0xFFFF_FFFF
//   -> o_rd_data stays 0x0000_007F, o_rd_wr stays 1.
//  ADD, rd=0, ALUout=0x1234 -> o_rd_wr=0. ADD, rd=5 -> o_rd_data=0x1234, o_rd_wr=1.
//  Flush+stall in the same cycle -> bubble. Assert rst mid-load -> all outputs 0 without waiting for clk.

Source files
------------

// File: rtl/wbu_pkg.sv
// Mnemonic encoding shared with decode/memu, plus load classification helper.
package wbu_pkg;

  localparam int MNEM_W = 6;

  localparam logic [MNEM_W-1:0] NOP  = 6'd0;
  localparam logic [MNEM_W-1:0] LB   = 6'd1;
  localparam logic [MNEM_W-1:0] LH   = 6'd2;
  localparam logic [MNEM_W-1:0] LW   = 6'd3;
  localparam logic [MNEM_W-1:0] LBU  = 6'd4;
  localparam logic [MNEM_W-1:0] LHU  = 6'd5;
  localparam logic [MNEM_W-1:0] SB   = 6'd6;
  localparam logic [MNEM_W-1:0] SH   = 6'd7;
  localparam logic [MNEM_W-1:0] SW   = 6'd8;
  localparam logic [MNEM_W-1:0] ADD  = 6'd9;
  localparam logic [MNEM_W-1:0] SUB  = 6'd10;
  localparam logic [MNEM_W-1:0] ADDI = 6'd11;
  localparam logic [MNEM_W-1:0] BEQ  = 6'd12;
  localparam logic [MNEM_W-1:0] BNE  = 6'd13;

  // True for the five RV32I load mnemonics.
  function automatic logic is_load(input logic [MNEM_W-1:0] m);
    return (m == LB) || (m == LH) || (m == LW) || (m == LBU) || (m == LHU);
  endfunction

endpackage

// File: rtl/wbu_mem_wb.sv
// MEM/WB pipeline register: stall holds, flush inserts a NOP bubble (flush wins).
module wbu_mem_wb
  import wbu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                flush,
  input  logic [MNEM_W-1:0]   mnemonic,
  input  logic [4:0]          rd_addr,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                rd_wr,
  output logic [MNEM_W-1:0]   mnem_p1,
  output logic [4:0]          rd_addr_p1,
  output logic [DATA_W-1:0]   alu_out_p1,
  output logic                rd_wr_p1
);

  // Stage register MEM -> WB; async active-low reset clears to a NOP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mnem_p1    <= NOP;
      rd_addr_p1 <= '0;
      alu_out_p1 <= '0;
      rd_wr_p1   <= 1'b0;
    end else if (flush) begin
      mnem_p1    <= NOP;
      rd_addr_p1 <= '0;
      alu_out_p1 <= '0;
      rd_wr_p1   <= 1'b0;
    end else if (!stall) begin
      mnem_p1    <= mnemonic;
      rd_addr_p1 <= rd_addr;
      alu_out_p1 <= alu_out;
      rd_wr_p1   <= rd_wr;
    end
  end

endmodule

// File: rtl/wbu.sv
// Write-back unit: MEM/WB register, load extraction/alignment, stall hold of
// load data, and the register-file write port.
module wbu
  import wbu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int HOLD_DO = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic [MNEM_W-1:0]   i_mnemonic,
  input  logic [4:0]          i_rd_addr,
  input  logic [DATA_W-1:0]   i_ALUout,
  input  logic                i_rd_wr,
  input  logic [DATA_W-1:0]   i_DM_DO,
  output logic [MNEM_W-1:0]   o_mnemonic,
  output logic [4:0]          o_rd_addr,
  output logic [DATA_W-1:0]   o_rd_data,
  output logic                o_rd_wr,
  output logic                o_is_load,
  output logic                o_misalign
);

  logic [MNEM_W-1:0] mnem_p1;
  logic [4:0]        rd_addr_p1;
  logic [DATA_W-1:0] alu_out_p1;
  logic              rd_wr_p1;

  logic [1:0]        off;
  logic [7:0]        byte_sel;
  logic [15:0]       half_sel;
  logic [DATA_W-1:0] wb_data;
  logic              misalign;

  logic [DATA_W-1:0] hold_q;
  logic              hold_vld;

  function automatic logic [DATA_W-1:0] sext8(input logic signed [7:0] b);
    return {{(DATA_W-8){b[7]}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] zext8(input logic [7:0] b);
    return {{(DATA_W-8){1'b0}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic signed [15:0] h);
    return {{(DATA_W-16){h[15]}}, h};
  endfunction

  function automatic logic [DATA_W-1:0] zext16(input logic [15:0] h);
    return {{(DATA_W-16){1'b0}}, h};
  endfunction

  wbu_mem_wb #(
    .DATA_W (DATA_W)
  ) u_mem_wb (
    .clk        (clk),
    .rst        (rst),
    .stall      (i_stall),
    .flush      (i_flush),
    .mnemonic   (i_mnemonic),
    .rd_addr    (i_rd_addr),
    .alu_out    (i_ALUout),
    .rd_wr      (i_rd_wr),
    .mnem_p1    (mnem_p1),
    .rd_addr_p1 (rd_addr_p1),
    .alu_out_p1 (alu_out_p1),
    .rd_wr_p1   (rd_wr_p1)
  );

  // Load alignment: pick byte/half from the live DM word, extend, flag misalignment.
  always_comb begin
    off      = alu_out_p1[1:0];
    byte_sel = i_DM_DO[7:0];
    case (off)
      2'd1:    byte_sel = i_DM_DO[15:8];
      2'd2:    byte_sel = i_DM_DO[23:16];
      2'd3:    byte_sel = i_DM_DO[31:24];
      default: byte_sel = i_DM_DO[7:0];
    endcase
    half_sel = off[1] ? i_DM_DO[31:16] : i_DM_DO[15:0];
    wb_data  = alu_out_p1;
    misalign = 1'b0;
    case (mnem_p1)
      LB:  wb_data = sext8(byte_sel);
      LBU: wb_data = zext8(byte_sel);
      LH: begin
        wb_data  = sext16(half_sel);
        misalign = off[0];
      end
      LHU: begin
        wb_data  = zext16(half_sel);
        misalign = off[0];
      end
      LW: begin
        wb_data  = i_DM_DO;
        misalign = (off != 2'd0);
      end
      default: wb_data = alu_out_p1;
    endcase
  end

  // Stall hold: the SRAM output may move while stalled, so the first stall
  // edge snapshots the write-back value and later stall edges keep it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q   <= '0;
      hold_vld <= 1'b0;
    end else if (i_flush) begin
      hold_vld <= 1'b0;
    end else if (i_stall) begin
      if ((HOLD_DO != 0) && !hold_vld) begin
        hold_q   <= wb_data;
        hold_vld <= 1'b1;
      end
    end else begin
      hold_vld <= 1'b0;
    end
  end

  assign o_mnemonic = mnem_p1;
  assign o_rd_addr  = rd_addr_p1;
  assign o_rd_data  = hold_vld ? hold_q : wb_data;
  assign o_is_load  = is_load(mnem_p1);
  assign o_misalign = misalign;
  assign o_rd_wr    = rd_wr_p1 & (rd_addr_p1 != 5'd0) & ~misalign;

endmodule

// File: tb/tb_wbu.sv
// Bench for wbu: table of single-instruction vectors scored through a queue,
// plus hand sequences for stall hold, flush+stall and asynchronous reset.
module tb_wbu;
  import wbu_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_stall;
  logic              i_flush;
  logic [5:0]        i_mnemonic;
  logic [4:0]        i_rd_addr;
  logic [31:0]       i_ALUout;
  logic              i_rd_wr;
  logic [31:0]       i_DM_DO;
  logic [5:0]        o_mnemonic;
  logic [4:0]        o_rd_addr;
  logic [31:0]       o_rd_data;
  logic              o_rd_wr;
  logic              o_is_load;
  logic              o_misalign;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [5:0]  mnem;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic        wr;
    logic [31:0] dout;
    logic [31:0] e_data;
    logic        e_wr;
    logic        e_mis;
    logic        e_load;
    logic        chk_data;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        wr;
    logic        mis;
    logic        load;
    logic        chk_data;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[14];

  wbu #(
    .DATA_W  (32),
    .HOLD_DO (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_stall    (i_stall),
    .i_flush    (i_flush),
    .i_mnemonic (i_mnemonic),
    .i_rd_addr  (i_rd_addr),
    .i_ALUout   (i_ALUout),
    .i_rd_wr    (i_rd_wr),
    .i_DM_DO    (i_DM_DO),
    .o_mnemonic (o_mnemonic),
    .o_rd_addr  (o_rd_addr),
    .o_rd_data  (o_rd_data),
    .o_rd_wr    (o_rd_wr),
    .o_is_load  (o_is_load),
    .o_misalign (o_misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mnem"},  32'(o_mnemonic), 32'(NOP));
    chk({tag, ".rd"},    32'(o_rd_addr),  32'h0);
    chk({tag, ".data"},  o_rd_data,       32'h0);
    chk({tag, ".wr"},    32'(o_rd_wr),    32'h0);
    chk({tag, ".load"},  32'(o_is_load),  32'h0);
    chk({tag, ".mis"},   32'(o_misalign), 32'h0);
  endtask

  // Drive one instruction into MEM, present its DM word one edge later,
  // then score the WB outputs against the queued expectation.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    exp_t g;
    @(negedge clk);
    i_stall    = 1'b0;
    i_flush    = 1'b0;
    i_mnemonic = v.mnem;
    i_rd_addr  = v.rd;
    i_ALUout   = v.alu;
    i_rd_wr    = v.wr;
    e.rd       = v.rd;
    e.data     = v.e_data;
    e.wr       = v.e_wr;
    e.mis      = v.e_mis;
    e.load     = v.e_load;
    e.chk_data = v.chk_data;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    i_DM_DO = v.dout;
    #1;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL vec%0d.scoreboard: queue empty", idx);
    end else begin
      g = sb_q.pop_front();
      chk($sformatf("vec%0d.rd", idx),   32'(o_rd_addr),  32'(g.rd));
      chk($sformatf("vec%0d.wr", idx),   32'(o_rd_wr),    32'(g.wr));
      chk($sformatf("vec%0d.mis", idx),  32'(o_misalign), 32'(g.mis));
      chk($sformatf("vec%0d.load", idx), 32'(o_is_load),  32'(g.load));
      if (g.chk_data)
        chk($sformatf("vec%0d.data", idx), o_rd_data, g.data);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;

    //           mnem  rd     alu          wr    dout           e_data         e_wr  e_mis e_load chk
    vecs[0]  = '{LB,   5'd1,  32'h103,     1'b1, 32'h80FF_1234, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1]  = '{LHU,  5'd2,  32'h202,     1'b1, 32'h8001_5555, 32'h0000_8001, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[2]  = '{LH,   5'd2,  32'h202,     1'b1, 32'h8001_5555, 32'hFFFF_8001, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{LW,   5'd4,  32'h101,     1'b1, 32'h1111_2222, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{LW,   5'd4,  32'h100,     1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{ADD,  5'd0,  32'h1234,    1'b1, 32'hAAAA_AAAA, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{ADD,  5'd5,  32'h1234,    1'b1, 32'hAAAA_AAAA, 32'h0000_1234, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{LBU,  5'd6,  32'h0301,    1'b1, 32'h0000_A500, 32'h0000_00A5, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[8]  = '{LB,   5'd7,  32'h0302,    1'b1, 32'h0080_0000, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[9]  = '{LH,   5'd8,  32'h0401,    1'b1, 32'h0000_8000, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{LH,   5'd8,  32'h0400,    1'b1, 32'h1234_8000, 32'hFFFF_8000, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{SW,   5'd9,  32'h0500,    1'b0, 32'h5555_5555, 32'h0000_0500, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{LB,   5'd0,  32'h0600,    1'b1, 32'h0000_0011, 32'h0000_0011, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[13] = '{LHU,  5'd10, 32'h0703,    1'b1, 32'hFFFF_0000, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0};

    rst        = 1'b0;
    i_stall    = 1'b0;
    i_flush    = 1'b0;
    i_mnemonic = LW;
    i_rd_addr  = 5'd3;
    i_ALUout   = 32'h100;
    i_rd_wr    = 1'b1;
    i_DM_DO    = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 14; i++) apply(vecs[i], i);

    // Stall hold: LB captures 0x7F, DM word then changes while stalled.
    v = '{LB, 5'd3, 32'h0800, 1'b1, 32'h0000_007F, 32'h0000_007F, 1'b1, 1'b0, 1'b1, 1'b1};
    apply(v, 100);
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      i_DM_DO = 32'hFFFF_FFFF;
      #1;
      chk($sformatf("stall%0d.data", k), o_rd_data,       32'h0000_007F);
      chk($sformatf("stall%0d.wr", k),   32'(o_rd_wr),    32'h1);
      chk($sformatf("stall%0d.rd", k),   32'(o_rd_addr),  32'h3);
    end
    @(negedge clk);
    i_stall = 1'b0;

    // After the stall releases, the next load must use live DM data again.
    v = '{LBU, 5'd11, 32'h0903, 1'b1, 32'hC300_0000, 32'h0000_00C3, 1'b1, 1'b0, 1'b1, 1'b1};
    apply(v, 101);

    // Flush and stall together: flush wins, a bubble enters WB.
    v = '{ADD, 5'd5, 32'h0000_4321, 1'b1, 32'h0, 32'h0000_4321, 1'b1, 1'b0, 1'b0, 1'b1};
    apply(v, 102);
    i_stall = 1'b1;
    i_flush = 1'b1;
    @(posedge clk);
    #2;
    chk_all_zero("flush_stall");
    @(negedge clk);
    i_stall = 1'b0;
    i_flush = 1'b0;

    // Asynchronous reset in the middle of a stalled load.
    v = '{LW, 5'd7, 32'h0100, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b1, 1'b1};
    apply(v, 103);
    i_stall = 1'b1;
    @(posedge clk);
    #2;
    chk("rst_mid.pre_data", o_rd_data, 32'hCAFE_F00D);
    rst = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    @(negedge clk);
    i_stall = 1'b0;
    rst     = 1'b1;

    // Hold state must be gone after reset: a fresh LW reads the live word.
    v = '{LW, 5'd12, 32'h0200, 1'b1, 32'h0BAD_CAFE, 32'h0BAD_CAFE, 1'b1, 1'b0, 1'b1, 1'b1};
    apply(v, 104);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
